// File: rtl/timer_top.sv
// Pixel timing base: divides clk by DIV into a registered pixel_clk and counts
// pixel ticks 0..ROLLOVER-1, pulsing flag for one clk on each wrap.
`timescale 1ns/1ps

module timer_top #(
    parameter int DIV      = 6,
    parameter int ROLLOVER = 800
) (
    input  logic       clk,
    input  logic       n_rst,
    input  logic       s_rst,
    input  logic       enable,
    output logic       flag,
    output logic [9:0] countout,
    output logic       pixel_clk
);

    localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0] LAST_PRE = PW'(DIV - 1);
    localparam logic [PW-1:0] HALF_PRE = PW'(DIV / 2);
    localparam logic [9:0]    LAST_CNT = 10'(ROLLOVER - 1);

    logic [PW-1:0] pre_cnt_q, pre_cnt_d;
    logic [9:0]    count_q, count_d;
    logic          flag_q, flag_d;
    logic          pixel_clk_q, pixel_clk_d;
    logic [PW-1:0] pre_nxt;
    logic          tick;

    always_comb begin
        pre_nxt     = (pre_cnt_q == LAST_PRE) ? '0 : pre_cnt_q + 1'b1;
        tick        = enable && (pre_cnt_q == LAST_PRE);
        pre_cnt_d   = pre_cnt_q;
        count_d     = count_q;
        pixel_clk_d = pixel_clk_q;
        flag_d      = 1'b0;
        if (s_rst) begin
            pre_cnt_d   = '0;
            count_d     = '0;
            pixel_clk_d = 1'b0;
        end else if (enable) begin
            pre_cnt_d   = pre_nxt;
            pixel_clk_d = (pre_nxt >= HALF_PRE);
            if (tick) begin
                // Exact compare also covers ROLLOVER=1024, where LAST_CNT is all ones.
                if (count_q == LAST_CNT) begin
                    count_d = '0;
                    flag_d  = 1'b1;
                end else begin
                    count_d = count_q + 10'd1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            pre_cnt_q   <= '0;
            count_q     <= '0;
            flag_q      <= 1'b0;
            pixel_clk_q <= 1'b0;
        end else begin
            pre_cnt_q   <= pre_cnt_d;
            count_q     <= count_d;
            flag_q      <= flag_d;
            pixel_clk_q <= pixel_clk_d;
        end
    end

    assign flag      = flag_q;
    assign countout  = count_q;
    assign pixel_clk = pixel_clk_q;

endmodule

// File: tb/tb_timer_top.sv
// Directed bench for timer_top at default parameters (DIV=6, ROLLOVER=800).
`timescale 1ns/1ps

module tb_timer_top;

    logic       clk = 1'b0;
    logic       n_rst;
    logic       s_rst;
    logic       enable;
    logic       flag;
    logic [9:0] countout;
    logic       pixel_clk;

    int n_checks = 0;
    int n_fail   = 0;
    int flag_seen;

    timer_top dut (
        .clk       (clk),
        .n_rst     (n_rst),
        .s_rst     (s_rst),
        .enable    (enable),
        .flag      (flag),
        .countout  (countout),
        .pixel_clk (pixel_clk)
    );

    always #3.33 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // One rising edge, then settle to the falling edge where sampling and driving happen.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic sync_clear();
        s_rst = 1'b1;
        step();
        s_rst = 1'b0;
    endtask

    initial begin
        n_rst  = 1'b0;
        s_rst  = 1'b1;
        enable = 1'b0;

        // Reset release and hold under s_rst
        #1 n_rst = 1'b1;
        #0.5;
        check("rst_count", countout, 0);
        check("rst_flag", flag, 0);
        check("rst_pix", pixel_clk, 0);
        step();
        step();
        check("srst_hold_count", countout, 0);
        check("srst_hold_pix", pixel_clk, 0);
        $display("phase 1: reset done");

        // First pixel period
        s_rst  = 1'b0;
        enable = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            step();
            check("p2_pix", pixel_clk, (i >= 3 && i <= 5) ? 1 : 0);
            check("p2_count", countout, (i == 6) ? 1 : 0);
            check("p2_flag", flag, 0);
        end
        $display("phase 2: first pixel period done");

        // Full 4800-clk period from clear
        sync_clear();
        flag_seen = 0;
        for (int n = 1; n <= 4801; n++) begin
            step();
            if (flag) flag_seen++;
            check("p3_count", countout, (n / 6) % 800);
            check("p3_pix", pixel_clk, ((n % 6) >= 3) ? 1 : 0);
            check("p3_flag", flag, (n == 4800) ? 1 : 0);
            if (n == 4794) check("p3_count_799", countout, 799);
        end
        check("p3_flag_pulses", flag_seen, 1);
        $display("phase 3: wrap period done");

        // Enable gap at pre_cnt=2, countout=5
        sync_clear();
        repeat (32) step();
        check("p4_pre_gap_count", countout, 5);
        enable = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            check("p4_gap_count", countout, 5);
            check("p4_gap_pix", pixel_clk, 0);
            check("p4_gap_flag", flag, 0);
        end
        enable = 1'b1;
        repeat (3) step();
        check("p4_resume3_count", countout, 5);
        check("p4_resume3_pix", pixel_clk, 1);
        step();
        check("p4_resume4_count", countout, 6);
        check("p4_resume4_pix", pixel_clk, 0);
        $display("phase 4: enable gap done");

        // Sync clear on the wrap tick
        sync_clear();
        repeat (4799) step();
        check("p5_pre_count", countout, 799);
        check("p5_pre_pix", pixel_clk, 1);
        s_rst = 1'b1;
        step();
        check("p5_count", countout, 0);
        check("p5_pix", pixel_clk, 0);
        check("p5_flag", flag, 0);
        s_rst = 1'b0;
        step();
        check("p5_after_flag", flag, 0);
        check("p5_after_count", countout, 0);
        $display("phase 5: clear at wrap done");

        // Async reset mid-count
        sync_clear();
        repeat (22) step();
        check("p6_pre_count", countout, 3);
        check("p6_pre_pix", pixel_clk, 1);
        #1 n_rst = 1'b0;
        #0.5;
        check("p6_async_count", countout, 0);
        check("p6_async_pix", pixel_clk, 0);
        check("p6_async_flag", flag, 0);
        #0.5 n_rst = 1'b1;
        @(negedge clk);
        repeat (3) step();
        check("p6_restart_pix", pixel_clk, 1);
        repeat (3) step();
        check("p6_restart_count", countout, 1);
        check("p6_restart_pix_low", pixel_clk, 0);
        $display("phase 6: async reset done");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
